// File: rtl/seq_mul_issuer.sv
// ---------------------------------------------------------------------------
// seq_mul_issuer
//
// Issue and capture stage wrapped around seq_multiplier. That multiplier
// produces one signed product per fixed LATENCY-cycle slot and runs its own
// slot counter from the same clk/reset nets. This block keeps a matching
// phase counter so that:
//   - operands on mul_a/mul_b change only at slot boundaries and stay
//     constant for the whole slot;
//   - the product of a slot is captured on the boundary edge that ends it.
// Results are buffered in a 2-entry FIFO. An operand pair is only issued if
// that FIFO is guaranteed to have room when its product arrives, so a
// stalled consumer produces empty (bubble) slots and never loses a result.
//
// Ports
//   clk, reset            shared with seq_multiplier; reset is async, high
//   in_valid/in_ready     operand handshake; in_ready = hold register empty
//   in_a, in_b            signed operands (WIDTH bits)
//   mul_a, mul_b          operands driven to seq_multiplier for the slot
//   mul_result            signed product from seq_multiplier (2*WIDTH bits)
//   out_valid/out_ready   result handshake; out_valid = FIFO non-empty
//   out_product           head-of-FIFO product (2*WIDTH bits)
//   slot_busy             current slot carries a real operand pair
// ---------------------------------------------------------------------------
module seq_mul_issuer #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic [WIDTH-1:0]     mul_a,
   output logic [WIDTH-1:0]     mul_b,
   input  logic [2*WIDTH-1:0]   mul_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic                 slot_busy
);

   localparam int            PW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [PW-1:0] PH_LAST = PW'(LATENCY - 1);

   // Phase counter, aligned with the multiplier's internal slot counter.
   logic [PW-1:0]        ph_q, ph_d;

   // Hold register for one accepted operand pair awaiting issue.
   logic                 hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0]     hold_a_q, hold_a_d;
   logic [WIDTH-1:0]     hold_b_q, hold_b_d;

   // Operands presented to the multiplier for the current slot.
   logic [WIDTH-1:0]     mul_a_q, mul_a_d;
   logic [WIDTH-1:0]     mul_b_q, mul_b_d;
   logic                 slot_busy_q, slot_busy_d;

   // Two-entry output FIFO kept as head/tail registers; head is always the
   // oldest entry so out_product needs no read mux.
   logic [2*WIDTH-1:0]   head_q, head_d;
   logic [2*WIDTH-1:0]   tail_q, tail_d;
   logic [1:0]           count_q, count_d;

   logic                 boundary;
   logic                 accept;
   logic                 capture;
   logic                 pop;
   logic                 issue;
   logic [1:0]           occ_after;

   assign boundary  = (ph_q == PH_LAST);
   assign accept    = in_valid && !hold_valid_q;
   assign capture   = boundary && slot_busy_q;
   assign pop       = (count_q != 2'd0) && out_ready;
   // Occupancy once this edge has committed. Issuing only when this is at
   // most one leaves a free entry for the product that arrives a slot later.
   assign occ_after = count_q + {1'b0, capture} - {1'b0, pop};
   assign issue     = boundary && hold_valid_q && (occ_after <= 2'd1);

   // Phase counter
   always_comb begin
      ph_d = boundary ? '0 : ph_q + 1'b1;
   end

   // Hold register. accept needs an empty hold and issue needs a full one,
   // so the two never coincide: a same-edge accept only happens when the
   // hold was already empty before the edge.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_a_d     = hold_a_q;
      hold_b_d     = hold_b_q;
      if (issue) begin
         hold_valid_d = 1'b0;
      end
      if (accept) begin
         hold_valid_d = 1'b1;
         hold_a_d     = in_a;
         hold_b_d     = in_b;
      end
   end

   // Slot operands: updated only at boundaries, zeroed for bubble slots.
   always_comb begin
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      slot_busy_d = slot_busy_q;
      if (boundary) begin
         if (issue) begin
            mul_a_d     = hold_a_q;
            mul_b_d     = hold_b_q;
            slot_busy_d = 1'b1;
         end else begin
            mul_a_d     = '0;
            mul_b_d     = '0;
            slot_busy_d = 1'b0;
         end
      end
   end

   // Output FIFO. The issue rule guarantees capture never meets a full FIFO.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case ({capture, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               head_d = mul_result;
            end else begin
               tail_d = mul_result;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            // Emptied head reads back as zero rather than a stale product.
            head_d  = (count_q == 2'd2) ? tail_q : '0;
            tail_d  = '0;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               head_d = mul_result;
            end else begin
               head_d = tail_q;
               tail_d = mul_result;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ph_q         <= '0;
         hold_valid_q <= 1'b0;
         hold_a_q     <= '0;
         hold_b_q     <= '0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         slot_busy_q  <= 1'b0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= 2'd0;
      end else begin
         ph_q         <= ph_d;
         hold_valid_q <= hold_valid_d;
         hold_a_q     <= hold_a_d;
         hold_b_q     <= hold_b_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         slot_busy_q  <= slot_busy_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
      end
   end

   assign in_ready    = !hold_valid_q;
   assign mul_a       = mul_a_q;
   assign mul_b       = mul_b_q;
   assign slot_busy   = slot_busy_q;
   assign out_valid   = (count_q != 2'd0);
   assign out_product = head_q;

   // A capture into a full FIFO would drop a product.
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(capture && (count_q == 2'd2)));
      end
   end

endmodule

// File: tb/tb_seq_mul_issuer.sv
module tb_seq_mul_issuer;
   localparam int W   = 32;
   localparam int LAT = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [W-1:0]     in_a = '0;
   logic [W-1:0]     in_b = '0;
   logic [W-1:0]     mul_a;
   logic [W-1:0]     mul_b;
   logic [2*W-1:0]   mul_result;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [2*W-1:0]   out_product;
   logic             slot_busy;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc;

   always #5 clk = ~clk;

   // Cycle index since reset release; also the multiplier's slot phase source.
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Multiplier model: the product is only valid in the last cycle of a slot,
   // so a capture at the wrong edge picks up the junk pattern.
   logic signed [2*W-1:0] model_prod;
   assign model_prod = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
   assign mul_result = ((cyc % LAT) == LAT - 1) ? model_prod : 64'hDEAD_BEEF_0BAD_F00D;

   seq_mul_issuer #(.WIDTH(W), .LATENCY(LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_result  (mul_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .slot_busy   (slot_busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic advance_to(input int c);
      while (cyc < c) step();
   endtask

   // Leaves the bench in cycle 0 (ph=0) right after reset release.
   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
      n_checks++; if ({mul_a, mul_b} !== 64'd0) $display("FAIL reset_mul_ops: got %h/%h want 0/0", mul_a, mul_b); else n_pass++;
      n_checks++; if ({slot_busy, out_valid} !== 2'b00) $display("FAIL reset_flags: got busy=%b valid=%b want 0 0", slot_busy, out_valid); else n_pass++;
      n_checks++; if (out_product !== 64'd0) $display("FAIL reset_product: got %h want 0", out_product); else n_pass++;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = 35; in_b = 96;
      step();
      in_valid = 1'b0;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL single_in_ready_held: got %b want 0", in_ready); else n_pass++;
      advance_to(31);
      n_checks++; if ({mul_a, mul_b} !== 64'd0) $display("FAIL single_ops_before_issue: got %0d/%0d want 0/0", mul_a, mul_b); else n_pass++;
      advance_to(32);
      n_checks++; if ({slot_busy, mul_a, mul_b} !== {1'b1, 32'd35, 32'd96}) $display("FAIL single_issue_c32: got busy=%b %0d/%0d want 1 35/96", slot_busy, mul_a, mul_b); else n_pass++;
      advance_to(63);
      n_checks++; if ({out_valid, mul_a, mul_b} !== {1'b0, 32'd35, 32'd96}) $display("FAIL single_c63: got valid=%b %0d/%0d want 0 35/96", out_valid, mul_a, mul_b); else n_pass++;
      advance_to(64);
      n_checks++; if ({out_valid, out_product} !== {1'b1, 64'd3360}) $display("FAIL single_result_c64: got valid=%b prod=%0d want 1 3360", out_valid, out_product); else n_pass++;
      n_checks++; if ({slot_busy, mul_a} !== {1'b0, 32'd0}) $display("FAIL single_bubble_c64: got busy=%b a=%0d want 0 0", slot_busy, mul_a); else n_pass++;
      step();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL single_popped: got valid=%b want 0", out_valid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int     pa[5] = '{-15, -17, 1, 0, 36};
      int     pb[5] = '{20, -17, 40, 64, 42};
      longint pe[5] = '{-300, 289, 40, 0, 1512};
      int     idx;
      int     waited;
      do_reset();
      out_ready = 1'b1;
      idx = 0;
      fork
         begin
            for (int k = 0; k < 5; k++) begin
               in_valid = 1'b1; in_a = pa[k]; in_b = pb[k];
               waited = 0;
               while (in_ready !== 1'b1 && waited < 100) begin step(); waited++; end
               if (waited >= 100) begin
                  n_checks++; $display("FAIL b2b_accept_timeout: pair %0d not accepted within 100 cycles", k);
               end
               step();
            end
            in_valid = 1'b0;
         end
         begin
            for (int t = 0; t < 260 && idx < 5; t++) begin
               if (out_valid === 1'b1) begin
                  n_checks++;
                  if (out_product !== pe[idx] || cyc != 64 + 32 * idx)
                     $display("FAIL b2b_result%0d: got %0d at cycle %0d want %0d at cycle %0d", idx, $signed(out_product), cyc, pe[idx], 64 + 32 * idx);
                  else n_pass++;
                  idx++;
               end
               if (cyc >= 32 && cyc <= 160 && (cyc % 32) == 0) begin
                  n_checks++;
                  if ({slot_busy, mul_a, mul_b} !== {1'b1, pa[cyc/32 - 1], pb[cyc/32 - 1]})
                     $display("FAIL b2b_slot_c%0d: got busy=%b %0d/%0d want 1 %0d/%0d", cyc, slot_busy, $signed(mul_a), $signed(mul_b), pa[cyc/32 - 1], pb[cyc/32 - 1]);
                  else n_pass++;
               end
               step();
            end
         end
      join
      if (idx != 5) begin
         n_checks++; $display("FAIL b2b_timeout: got %0d results want 5", idx);
      end
   endtask

   task automatic test_stall();
      longint e3 = -21;
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 165; in_b = 348;
      step();
      in_valid = 1'b0;
      advance_to(32);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL stall_ready_c32: got %b want 1", in_ready); else n_pass++;
      in_valid = 1'b1; in_a = 3672; in_b = 9648;
      step();
      in_valid = 1'b0;
      advance_to(64);
      n_checks++; if ({out_valid, out_product} !== {1'b1, 64'd57420}) $display("FAIL stall_first_c64: got valid=%b prod=%0d want 1 57420", out_valid, out_product); else n_pass++;
      in_valid = 1'b1; in_a = 7; in_b = -3;
      step();
      in_valid = 1'b0;
      advance_to(96);
      n_checks++; if ({in_ready, slot_busy, mul_a, mul_b} !== {1'b0, 1'b0, 32'd0, 32'd0}) $display("FAIL stall_bubble_c96: got ready=%b busy=%b %0d/%0d want 0 0 0/0", in_ready, slot_busy, mul_a, mul_b); else n_pass++;
      advance_to(199);
      n_checks++; if ({out_valid, out_product, in_ready} !== {1'b1, 64'd57420, 1'b0}) $display("FAIL stall_hold_c199: got valid=%b prod=%0d ready=%b want 1 57420 0", out_valid, out_product, in_ready); else n_pass++;
      advance_to(200);
      out_ready = 1'b1;
      step();
      n_checks++; if ({out_valid, out_product} !== {1'b1, 64'd35427456}) $display("FAIL stall_second_c201: got valid=%b prod=%0d want 1 35427456", out_valid, out_product); else n_pass++;
      step();
      n_checks++; if (out_valid !== 1'b0) $display("FAIL stall_drained_c202: got valid=%b want 0", out_valid); else n_pass++;
      advance_to(223);
      n_checks++; if ({in_ready, mul_a} !== {1'b0, 32'd0}) $display("FAIL stall_waiting_c223: got ready=%b a=%0d want 0 0", in_ready, mul_a); else n_pass++;
      advance_to(224);
      n_checks++; if ({slot_busy, mul_a, mul_b, in_ready} !== {1'b1, 32'd7, -32'sd3, 1'b1}) $display("FAIL stall_reissue_c224: got busy=%b %0d/%0d ready=%b want 1 7/-3 1", slot_busy, $signed(mul_a), $signed(mul_b), in_ready); else n_pass++;
      advance_to(256);
      n_checks++; if (out_valid !== 1'b1 || out_product !== e3) $display("FAIL stall_third_c256: got valid=%b prod=%0d want 1 -21", out_valid, $signed(out_product)); else n_pass++;
   endtask

   task automatic test_mid_accept();
      longint e = -60;
      do_reset();
      out_ready = 1'b1;
      advance_to(17);
      n_checks++; if (in_ready !== 1'b1) $display("FAIL mid_ready_c17: got %b want 1", in_ready); else n_pass++;
      in_valid = 1'b1; in_a = 12; in_b = -5;
      step();
      in_valid = 1'b0;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL mid_ready_c18: got %b want 0", in_ready); else n_pass++;
      advance_to(31);
      n_checks++; if ({in_ready, mul_a} !== {1'b0, 32'd0}) $display("FAIL mid_c31: got ready=%b a=%0d want 0 0", in_ready, mul_a); else n_pass++;
      advance_to(32);
      n_checks++; if ({in_ready, mul_a, mul_b} !== {1'b1, 32'd12, -32'sd5}) $display("FAIL mid_issue_c32: got ready=%b %0d/%0d want 1 12/-5", in_ready, $signed(mul_a), $signed(mul_b)); else n_pass++;
      advance_to(64);
      n_checks++; if (out_valid !== 1'b1 || out_product !== e) $display("FAIL mid_result_c64: got valid=%b prod=%0d want 1 -60", out_valid, $signed(out_product)); else n_pass++;
   endtask

   task automatic test_reset_mid();
      longint e = -56;
      int seen;
      int bad;
      do_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_a = 100; in_b = 200;
      step();
      in_valid = 1'b0;
      advance_to(32);
      in_valid = 1'b1; in_a = 9; in_b = 9;
      step();
      in_valid = 1'b0;
      advance_to(84);
      n_checks++; if ({out_valid, out_product, slot_busy} !== {1'b1, 64'd20000, 1'b1}) $display("FAIL rmid_pre: got valid=%b prod=%0d busy=%b want 1 20000 1", out_valid, out_product, slot_busy); else n_pass++;
      #2 reset = 1'b1;
      #1;
      n_checks++; if ({in_ready, slot_busy, out_valid} !== 3'b100) $display("FAIL rmid_flags: got ready=%b busy=%b valid=%b want 1 0 0", in_ready, slot_busy, out_valid); else n_pass++;
      n_checks++; if ({mul_a, mul_b} !== 64'd0 || out_product !== 64'd0) $display("FAIL rmid_data: got %0d/%0d prod=%0d want 0/0 0", mul_a, mul_b, out_product); else n_pass++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1; in_a = -7; in_b = 8;
      step();
      in_valid = 1'b0;
      seen = 0;
      bad = 0;
      for (int t = 0; t < 80; t++) begin
         if (out_valid === 1'b1) begin
            seen++;
            if (cyc != 64 || out_product !== e) bad++;
         end
         step();
      end
      n_checks++; if (seen != 1) $display("FAIL rmid_result_count: got %0d want 1", seen); else n_pass++;
      n_checks++; if (bad != 0) $display("FAIL rmid_result_value: got %0d wrong results want 0 (expect -56 at cycle 64)", bad); else n_pass++;
   endtask

   task automatic test_idle();
      int bad;
      do_reset();
      in_valid = 1'b0;
      out_ready = 1'b1;
      bad = 0;
      for (int t = 0; t < 100; t++) begin
         if ({mul_a, mul_b} !== 64'd0 || slot_busy !== 1'b0 || out_valid !== 1'b0) bad++;
         step();
      end
      n_checks++; if (bad != 0) $display("FAIL idle_quiet: got %0d active cycles want 0", bad); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL idle_ready: got %b want 1", in_ready); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_mid_accept();
      test_reset_mid();
      test_idle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/seq_mul_issuer.md
Name: seq_mul_issuer

Overview:
- Operand issue and result capture stage placed around seq_multiplier, the self-timed multiplier that computes one product per fixed LATENCY-cycle slot.
- Accepts operand pairs on a valid/ready interface and drives mul_a/mul_b so they are stable for a whole slot, aligned to the multiplier's slot boundaries.
- Captures the signed product at the end of each slot and returns it through a 2-entry output FIFO with valid/ready.
- Shares clk and reset with the multiplier so both slot counters stay aligned.

Parameters:
- WIDTH, 32, operand width; product width is 2*WIDTH.
- LATENCY, 32, cycles per multiplier slot; the product of a slot's operands is stable on mul_result by the last cycle of that slot.

Ports:
- clk  input  1  rising-edge clock, same net as seq_multiplier clk.
- reset  input  1  asynchronous, active-high; same net as seq_multiplier reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  hold register empty.
- in_a  input  WIDTH  operand A (two's complement).
- in_b  input  WIDTH  operand B (two's complement).
- mul_a  output  WIDTH  to seq_multiplier a.
- mul_b  output  WIDTH  to seq_multiplier b.
- mul_result  input  2*WIDTH  from seq_multiplier result (signed).
- out_valid  output  1  output FIFO non-empty.
- out_ready  input  1  consumer accepts the head entry.
- out_product  output  2*WIDTH  head-of-FIFO product (signed).
- slot_busy  output  1  current slot carries a real operand pair.

Behaviour:
- Reset (asynchronous, immediate):
  - ph=0; hold empty (in_ready=1); mul_a=mul_b=0; slot_busy=0.
  - Output FIFO emptied: out_valid=0, out_product=0.
  - An in-flight slot is abandoned; its product is never emitted.
- Phase counter ph, $clog2(LATENCY) bits:
  - Increments every cycle; wraps LATENCY-1 -> 0.
  - The boundary is the edge at the end of the ph==LATENCY-1 cycle.
- Input:
  - Handshake on in_valid && in_ready loads the hold register.
  - in_ready = !hold_valid, so no combinational path from out_ready.
- At each boundary edge, in this order:
  - Capture: if slot_busy, push mul_result into the FIFO.
  - Pop: a same-edge pop (out_valid && out_ready) counts.
  - Issue:
    - Condition: hold_valid and FIFO occupancy after this edge (old occupancy + capture - pop) <= 1.
    - If met: mul_a/mul_b <= hold, hold cleared, slot_busy <= 1.
    - Otherwise: mul_a=mul_b=0 and slot_busy <= 0 (bubble slot).
- Operands are constant for the entire slot and change only at boundary edges.
- Latency:
  - Pair accepted in the ph=0 cycle -> issued at the end of cycle LATENCY-1.
  - out_valid is high in cycle 2*LATENCY, counted from the accept cycle = 0.
- Throughput: one product per LATENCY cycles while the consumer keeps up. A stalled consumer causes bubble slots, never lost results.
- FIFO:
  - Two entries, first in first out.
  - out_product shows the head entry; it holds its value while out_valid && !out_ready.
  - Overflow is impossible by the issue rule. Assertion: no push when occupancy==2.
- Hold register: an accept in the same cycle as a boundary issue is allowed only if the hold register was empty before that edge. in_ready reflects the pre-edge state.
- Arithmetic: none inside the block; products pass through unchanged (full 2*WIDTH signed).

Test Plan:
- Release reset; push (35,96) in ph=0, out_ready=1 -> mul_a=35, mul_b=96 from cycle 32 to cycle 63; out_valid in cycle 64 with out_product=3360.
- Back-to-back pairs (-15,20), (-17,-17), (1,40), (0,64), (36,42) with out_ready=1 -> products -300, 289, 40, 0, 1512, one every 32 cycles in order, with no bubbles.
- Pairs (165,348) then (3672,9648) with out_ready=0 for 200 cycles -> FIFO holds 57420 then 35427456; the next pair is held (in_ready=0) and a bubble slot is issued with mul_a=mul_b=0; after out_ready=1, results drain in order and no product is lost.
- Pair accepted at ph=17 -> operands appear at the next ph=0; in_ready deasserts from the cycle after acceptance until the issue edge.
- Assert reset at ph=20 of a busy slot -> all outputs return to reset values immediately; no stale product ever appears; a pair accepted after release yields the correct product.
- Idle with in_valid=0 -> mul_a=mul_b=0, slot_busy=0, out_valid stays 0 indefinitely.
